// File: rtl/regfile_pkg.sv
// Shared constants for the parametrised register file and its scoreboard.
package regfile_pkg;

    localparam int REGFILE_N_DEF    = 8;
    localparam int REGFILE_NREG_DEF = 8;
    localparam int ZERO_REG         = 0;
    localparam int NRD              = 2;   // number of combinational read ports

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue, cleared by the
// producing write. Drives operand readiness and a sticky WAW error.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG = REGFILE_NREG_DEF,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            we3,
    input  logic [AW-1:0]   wa3,
    input  logic            iss_v,
    input  logic [AW-1:0]   iss_a,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic            rdy1,
    output logic            rdy2,
    output logic [NREG-1:0] pend,
    output logic            err
);

    logic [NREG-1:0] pend_q, pend_nxt, set_vec, clr_vec;
    logic            err_q;
    logic            wr_hit, iss_hit, waw;

    assign wr_hit  = we3   && (wa3   != AW'(ZERO_REG));
    assign iss_hit = iss_v && (iss_a != AW'(ZERO_REG));

    // Set is applied after clear so a re-issue in the write cycle stays pending.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (iss_hit) set_vec[iss_a] = 1'b1;
        if (wr_hit)  clr_vec[wa3]   = 1'b1;
        pend_nxt = (pend_q & ~clr_vec) | set_vec;
        pend_nxt[ZERO_REG] = 1'b0;
    end

    // A second producer only counts as WAW if the first is not retiring now.
    assign waw = iss_hit && pend_q[iss_a] && !(wr_hit && (wa3 == iss_a));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= '0;
            err_q  <= 1'b0;
        end else if (clr) begin
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_nxt;
            if (waw) err_q <= 1'b1;
        end
    end

    // wr_hit already excludes register 0, whose pend bit is never set.
    assign rdy1 = !rst || !pend_q[ra1] || (wr_hit && (wa3 == ra1));
    assign rdy2 = !rst || !pend_q[ra2] || (wr_hit && (wa3 == ra2));

    assign pend = pend_q;
    assign err  = err_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one write port, same-cycle
// write-through bypass and a pending-write scoreboard. r0 is hardwired to zero.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int N    = REGFILE_N_DEF,
    parameter  int NREG = REGFILE_NREG_DEF,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            we3,
    input  logic [AW-1:0]   wa3,
    input  logic [N-1:0]    wd3,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [N-1:0]    rd1,
    output logic [N-1:0]    rd2,
    input  logic            iss_v,
    input  logic [AW-1:0]   iss_a,
    output logic            rdy1,
    output logic            rdy2,
    output logic [NREG-1:0] pend,
    output logic            err
);

    logic [NREG-1:0][N-1:0] regs_q;
    logic                   wr_hit;
    logic [NRD-1:0][AW-1:0] ra;
    logic [NRD-1:0][N-1:0]  rd;

    assign wr_hit = we3 && (wa3 != AW'(ZERO_REG));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q <= '0;
        end else if (clr) begin
            regs_q <= '0;
        end else if (wr_hit) begin
            regs_q[wa3] <= wd3;
        end
    end

    assign ra = {ra2, ra1};

    // Bypass stays live during clr; outputs are forced to zero while in reset.
    for (genvar p = 0; p < NRD; p++) begin : g_rd
        assign rd[p] = (!rst || (ra[p] == AW'(ZERO_REG))) ? '0 :
                       (wr_hit && (wa3 == ra[p]))         ? wd3 :
                                                            regs_q[ra[p]];
    end

    assign rd1 = rd[0];
    assign rd2 = rd[1];

    regfile_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_sb (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .we3   (we3),
        .wa3   (wa3),
        .iss_v (iss_v),
        .iss_a (iss_a),
        .ra1   (ra1),
        .ra2   (ra2),
        .rdy1  (rdy1),
        .rdy2  (rdy2),
        .pend  (pend),
        .err   (err)
    );

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with two combinational read ports, one write port, same-cycle write-through bypass and a per-register pending-write scoreboard. It replaces the fixed 8×8 register file in the datapath. It lets the control unit mark a destination register as "in flight" at issue, and tells it whether each source operand is ready to read. Register 0 reads as zero and cannot be written.

## Interface
- N, 8, data width in bits
- NREG, 8, number of registers; power of two, ≥ 2
- AW, $clog2(NREG), address width; derived, not overridden
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear of all state
- we3  in  1  write enable
- wa3  in  AW  write address
- wd3  in  N  write data
- ra1, ra2  in  AW  read addresses
- rd1, rd2  out  N  read data
- iss_v  in  1  issue valid: mark iss_a pending
- iss_a  in  AW  destination register being issued
- rdy1, rdy2  out  1  source operand at ra1/ra2 is readable this cycle
- pend  out  NREG  scoreboard vector; bit i = register i pending
- err  out  1  sticky WAW error

## Operation
- **Reset** (rst = 0, asynchronous): all registers, pend and err go to 0. While rst = 0:
  - rd1 = rd2 = 0
  - rdy1 = rdy2 = 1
- **Write:** when we3 = 1 and wa3 ≠ 0, reg[wa3] ← wd3. Writes to address 0 are dropped.
- **Read:** rdX = reg[raX], combinational.
  - Bypass: if we3 = 1 and wa3 = raX ≠ 0, then rdX = wd3 in the same cycle.
  - raX = 0 always gives 0.
- **Scoreboard:**
  - Set: iss_v = 1 and iss_a ≠ 0 sets pend[iss_a].
  - Clear: we3 = 1 and wa3 ≠ 0 clears pend[wa3].
  - Set and clear on the same register in the same cycle: set wins (a new producer replaces the old one).
  - pend[0] is always 0.
- **Readiness:** rdyX = ~pend[raX] | (we3 & wa3 = raX & raX ≠ 0). Register 0 is always ready.
- **err:** set when iss_v = 1, iss_a ≠ 0, pend[iss_a] = 1, and the register is not being cleared by a write in the same cycle. err stays set until clr or rst.
- **clr** (synchronous): registers, pend and err go to 0. clr has priority over we3 and iss_v in the same cycle. Bypass is still combinationally active during a clr cycle.
- **Write to a non-pending register:** legal, with no side effect on pend.

## Timing
- Write latency: 1 cycle to array visibility, 0 cycles through the bypass.
- pend and err update on the clk edge and are visible the next cycle. rdy reflects a same-cycle write immediately.
- No handshake stalls: the block never backpressures. The control unit stalls on ~rdyX.
- Reset deassertion: first write takes effect on the first rising edge with rst = 1.
- An rst assertion in the middle of an in-flight sequence discards all pending state. There is no recovery of partial writes.

## Structure
- Package regfile_pkg holds:
  - REGFILE_N_DEF = 8, REGFILE_NREG_DEF = 8
  - the zero-register index constant ZERO_REG = 0
- Sub-module regfile_scoreboard (NREG, AW) contains:
  - the pend vector
  - set/clear priority
  - err generation
  - rdy logic, taking ra1/ra2/we3/wa3
- The top level holds the data array, write logic and bypass muxes.

## Test plan
- **Reset/zero register:** assert rst mid-run after writing 8'hAA to r3 → rd1 = 0 with ra1 = 3, pend = 0, err = 0. Then write 8'h55 to r0 → rd1 stays 0 with ra1 = 0.
- **Bypass:** we3 = 1, wa3 = 5, wd3 = 8'h3C, ra1 = ra2 = 5 in the same cycle → rd1 = rd2 = 8'h3C before the edge. After the edge, with we3 = 0 → still 8'h3C.
- **Scoreboard:**
  - iss r4 → next cycle pend[4] = 1, and rdy1 = 0 with ra1 = 4.
  - write r4 = 8'h11 → rdy1 = 1 in that same cycle, rd1 = 8'h11, pend[4] = 0 after the edge.
- **Simultaneous set/clear:** pend[2] = 1; in one cycle write r2 and iss r2 → after the edge pend[2] = 1 and err = 0.
- **WAW error:** iss r6 twice with no intervening write → err = 1 after the second edge. err stays 1 until clr, which also zeroes all registers and pend.
- **Parameter sweep:** N = 32, NREG = 32 → write distinct values to r1..r31, read back each on both ports. r0 = 0.
